// File: rtl/alu_seq_slice.sv
// Multi-cycle ALU: ADD/SUB/AND/OR over WIDTH bits, SLICE bits per clock through a registered carry.
// Define ALU_SEQ_FLAGS_EN to build the zero/ovf flag logic; otherwise both flags are tied low.
module alu_seq_slice #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} op_t;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic             carry_q;
  logic [IW-1:0]    idx;

  int               base;
  logic [SLICE-1:0] a_sl, b_sl, slice_val;
  logic [SLICE:0]   sum;
  logic             arith, carry_out, last;

  // One slice of the datapath, selected by the slice index.
  // NOTE: combinational logic uses blocking '=' with a default for every output first, so no latch is inferred.
  always_comb begin
    arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
    base      = int'(idx) * SLICE;
    a_sl      = a_q[base +: SLICE];
    b_sl      = b_q[base +: SLICE];
    if (op_q == OP_SUB) b_sl = ~b_sl;
    sum       = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);
    case (op_q)
      OP_AND:  slice_val = a_sl & b_sl;
      OP_OR:   slice_val = a_sl | b_sl;
      default: slice_val = sum[SLICE-1:0];
    endcase
    carry_out = arith & sum[SLICE];
    last      = (idx == LAST_IDX);
    res_next  = res_q;
    res_next[base +: SLICE] = slice_val;
  end

  // Control and visible outputs; outputs only change on DONE entry so the consumer sees a whole result.
  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      carry_q   <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            carry_q  <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          carry_q <= carry_out;
          idx     <= idx + IW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            s         <= res_next;
            cout      <= carry_out;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: operand and partial-result registers are not reset; each bit is written before it is used.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && in_ready) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_t'(op);
    end
    if (state == RUN) res_q <= res_next;
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Carry into the MSB is recovered as a^b^sum at that bit, so ovf needs no extra adder tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN && last) begin
      zero <= (res_next == '0);
      ovf  <= arith & (a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_val[SLICE-1] ^ carry_out);
    end
  end
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule
